intersection_ctrl: RTL

Two-road intersection controller that sequences a north-south (NS) and an east-west (EW) traffic signal head, plus an optional pedestrian walk phase. It generalises the single-head light FSM into a demand-actuated scheduler that shares the intersection between the two roads and pedestrians. It sits directly above the light drivers and is timed by an external 1-cycle `tick` time base.

---
 rtl/intersection_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/intersection_ctrl.sv
// Two-road demand-actuated intersection controller (NS rests green, EW actuated).
// Define INTERSECTION_PED_EN to enable the pedestrian walk phase and ped_req_i.
module intersection_ctrl #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 3,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       ew_sense_i,
  input  logic       ped_req_i,
  output logic [2:0] ns_lights_o,
  output logic [2:0] ew_lights_o,
  output logic       walk_o,
  output logic [2:0] phase_o
);

  typedef enum logic [2:0] {
    ALLRED_B  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_A  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] GMinLast   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMaxLast   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AllredLast = CNT_W'(ALLRED_T - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ew_dem_q, ew_dem_d;
  logic             ped_pend;

`ifdef INTERSECTION_PED_EN
  localparam logic [CNT_W-1:0] WalkLast = CNT_W'(WALK_T - 1);
  logic ped_pend_q, ped_pend_d;
  assign ped_pend = ped_pend_q;
`else
  localparam int unsigned walk_t_unused = WALK_T;
  logic ped_req_unused;
  assign ped_req_unused = ped_req_i;
  assign ped_pend       = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ALLRED_B;
      cnt_q      <= '0;
      ew_dem_q   <= 1'b0;
`ifdef INTERSECTION_PED_EN
      ped_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ew_dem_q   <= ew_dem_d;
`ifdef INTERSECTION_PED_EN
      ped_pend_q <= ped_pend_d;
`endif
    end
  end

  // Transitions use pre-edge latch values; illegal codes recover without a tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ALLRED_B:  if (tick_i && cnt_q == AllredLast)
                   state_d = ped_pend ? PED_WALK : NS_GREEN;
      NS_GREEN:  if (tick_i && cnt_q >= GMinLast && (ew_dem_q || ped_pend))
                   state_d = NS_YELLOW;
      NS_YELLOW: if (tick_i && cnt_q == YellowLast) state_d = ALLRED_A;
      ALLRED_A:  if (tick_i && cnt_q == AllredLast) state_d = EW_GREEN;
      EW_GREEN:  if (tick_i && (cnt_q == GMaxLast || (cnt_q >= GMinLast && !ew_sense_i)))
                   state_d = EW_YELLOW;
      EW_YELLOW: if (tick_i && cnt_q == YellowLast) state_d = ALLRED_B;
`ifdef INTERSECTION_PED_EN
      PED_WALK:  if (tick_i && cnt_q == WalkLast) state_d = NS_GREEN;
`endif
      default:   state_d = ALLRED_B;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick_i && !(state_q == NS_GREEN && cnt_q == GMinLast)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    ew_dem_d = (ew_dem_q || (ew_sense_i && state_q != EW_GREEN))
               && !(state_d == EW_GREEN && state_q != EW_GREEN);
`ifdef INTERSECTION_PED_EN
    ped_pend_d = (ped_pend_q || (ped_req_i && state_q != PED_WALK))
                 && !(state_d == PED_WALK && state_q != PED_WALK);
`endif
  end

  always_comb begin
    ns_lights_o = 3'b100;
    ew_lights_o = 3'b100;
    walk_o      = 1'b0;
    case (state_q)
      NS_GREEN:  ns_lights_o = 3'b001;
      NS_YELLOW: ns_lights_o = 3'b010;
      EW_GREEN:  ew_lights_o = 3'b001;
      EW_YELLOW: ew_lights_o = 3'b010;
`ifdef INTERSECTION_PED_EN
      PED_WALK:  walk_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign phase_o = state_q;

endmodule
